// File: rtl/icache_refill_axi_if.sv
// icache_refill_axi_if: cache refill request/return and AXI4 read-channel signal bundle
//   cache side : rd_req/rd_type/rd_addr -> rd_rdy ; ret_valid/ret_last/ret_data back to the cache
//   AR channel : arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid -> arready
//   R channel  : rid/rdata/rresp/rlast/rvalid -> rready
//   master = refill block, slave = cache plus AXI fabric
interface icache_refill_axi_if;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    modport master (
        input  rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
        output rd_rdy, ret_valid, ret_last, ret_data,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
    );
    modport slave (
        output rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
        input  rd_rdy, ret_valid, ret_last, ret_data,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
    );
endinterface

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: single-outstanding AXI4 read master servicing icache line/uncached refills
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : icache_refill_axi_if.master (cache request/return + AXI AR/R channels)
//   o_err  : sticky protocol-error flag, cleared only by reset
module icache_refill_axi #(
    parameter logic [3:0] ID         = 4'd0,
    parameter int         LINE_BEATS = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    icache_refill_axi_if.master        bus,
    output logic                       o_err
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;
    state_t      r_state;
    logic        r_rd_rdy, r_arvalid, r_rready, r_ret_valid, r_ret_last, r_err;
    logic [31:0] r_araddr, r_ret_data;
    logic [7:0]  r_arlen, r_cnt;
    logic [2:0]  r_arsize;
    logic        w_line, w_legal, w_end;
    assign w_line  = bus.rd_type == 3'b100;
    // byte/half/word are 000/001/010; anything else but a line is issued as a word
    assign w_legal = w_line || (!bus.rd_type[2] && bus.rd_type[1:0] != 2'b11);
    assign w_end   = r_cnt == r_arlen || bus.rlast;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rd_rdy    <= 1'b1;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= 32'd0;
            r_err       <= 1'b0;
            r_araddr    <= 32'd0;
            r_arlen     <= 8'd0;
            r_arsize    <= 3'd0;
            r_cnt       <= 8'd0;
        end else begin
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.rd_req) begin
                    r_araddr  <= w_line ? {bus.rd_addr[31:4], 4'h0} : bus.rd_addr;
                    r_arlen   <= w_line ? 8'(LINE_BEATS - 1) : 8'd0;
                    r_arsize  <= (w_legal && !w_line) ? {1'b0, bus.rd_type[1:0]} : 3'b010;
                    r_err     <= r_err | ~w_legal;
                    r_rd_rdy  <= 1'b0;
                    r_arvalid <= 1'b1;
                    r_state   <= S_AR;
                end
                S_AR: if (bus.arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_cnt     <= 8'd0;
                    r_state   <= S_R;
                end
                S_R: if (bus.rvalid) begin
                    if (bus.rid != ID) begin
                        // foreign-ID beat: consumed and dropped
                        r_err <= 1'b1;
                    end else begin
                        r_ret_valid <= 1'b1;
                        r_ret_data  <= bus.rdata;
                        r_cnt       <= r_cnt + 8'd1;
                        // rlast must coincide exactly with the arlen-th beat; both early and missing rlast are errors
                        r_err       <= r_err | (bus.rresp != 2'b00) | (bus.rlast != (r_cnt == r_arlen));
                        if (w_end) begin
                            r_ret_last <= 1'b1;
                            r_rready   <= 1'b0;
                            r_rd_rdy   <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign bus.rd_rdy    = r_rd_rdy;
    assign bus.ret_valid = r_ret_valid;
    assign bus.ret_last  = r_ret_last;
    assign bus.ret_data  = r_ret_data;
    assign bus.arid      = ID;
    assign bus.araddr    = r_araddr;
    assign bus.arlen     = r_arlen;
    assign bus.arsize    = r_arsize;
    assign bus.arburst   = 2'b01;
    assign bus.arlock    = 2'b00;
    assign bus.arcache   = 4'h0;
    assign bus.arprot    = 3'h0;
    assign bus.arvalid   = r_arvalid;
    assign bus.rready    = r_rready;
    assign o_err         = r_err;
endmodule
